// File: rtl/inst_enc.sv
// RV32I instruction encoder with a one-entry registered output stage and an emit-address counter.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alu_op,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic        addr_load,
    input  logic [31:0] addr_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] count
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_X
    } fmt_e;

    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] enc_word;
    logic        imm_ok;
    logic        accept;
    logic        take;
    logic        xfer;
    logic [31:0] base_addr;

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ctr_q, ctr_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    // Upper immediate bits only matter to the optional range check.
    logic        unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];

    always_comb begin
        fmt    = FMT_X;
        opcode = 7'b0000000;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        case (alu_op)
            6'd1:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b000; end
            6'd2:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000; end
            6'd3:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b001; end
            6'd4:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b100; end
            6'd5:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b101; end
            6'd6:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b110; end
            6'd7:  begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b111; end
            6'd8:  begin fmt = FMT_I; opcode = 7'b0000011; funct3 = 3'b010; end
            6'd9:  begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b000; end
            6'd10: begin fmt = FMT_S; opcode = 7'b0100011; funct3 = 3'b010; end
            6'd11: begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b000; end
            6'd12: begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b100; end
            6'd13: begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b101; end
            6'd14: begin fmt = FMT_J; opcode = 7'b1101111; end
            default: fmt = FMT_X;
        endcase
    end

    // Only the fields belonging to the format are placed; everything else stays zero.
    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_word = 32'h0;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = imm;

    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            FMT_B: imm_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
            FMT_J: imm_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign take      = accept && (fmt != FMT_X) && imm_ok;
    assign xfer      = valid_q && out_ready;
    assign base_addr = addr_load ? addr_in : ctr_q;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        ctr_d   = base_addr;
        err_d   = accept && !take;
        count_d = count_q + {15'd0, xfer};
        if (take) begin
            valid_d = 1'b1;
            inst_d  = enc_word;
            addr_d  = base_addr;
            ctr_d   = base_addr + 32'd4;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            addr_q  <= 32'h0;
            ctr_q   <= 32'h0;
            err_q   <= 1'b0;
            count_q <= 16'h0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            ctr_q   <= ctr_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
